// File: rtl/knn_vote.sv
// knn_vote: majority-class vote over the K nearest neighbours from the KNN core.
//   Snapshots nb on start, fetches each non-empty neighbour's label over a
//   req/ack handshake, tallies votes per class, scans for the winner and holds
//   it on a valid/ready output.
// Latency: start edge t -> class_valid set at edge t+K+C (high in cycle t+1+K+C),
//   plus one cycle per lbl_ack wait cycle.
// Backpressure: the result is held in DONE until class_ready; start is ignored
//   unless IDLE; lbl_req/lbl_addr are held until lbl_ack.
// Ports: clk, rst (sync, active-high), start, nb (K x {index,dist});
//   lbl_req/lbl_addr/lbl_ack/lbl_data label lookup; class_out/class_valid/
//   class_ready result; busy, no_vote, lbl_err status.
// Build option: define KNN_VOTE_TIEBRK_EN to break count ties by the smaller
//   minimum neighbour distance (lowest class number if still tied).
module knn_vote #(
  parameter int DATA_W = 32,
  parameter int K      = 4,
  parameter int C      = 4,
  parameter int LBL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [2*K*DATA_W-1:0]   nb,
  output logic                    lbl_req,
  output logic [DATA_W-1:0]       lbl_addr,
  input  logic                    lbl_ack,
  input  logic [LBL_W-1:0]        lbl_data,
  output logic [LBL_W-1:0]        class_out,
  output logic                    class_valid,
  input  logic                    class_ready,
  output logic                    busy,
  output logic                    no_vote,
  output logic                    lbl_err
);

  localparam int CNT_W = $clog2(K + 1);
  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
  localparam int SC_W  = (C > 1) ? $clog2(C) : 1;
  localparam logic [DATA_W-1:0] EMPTY = '1;

  typedef enum logic [1:0] {IDLE, FETCH, SCAN, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] snap_idx [K];
  logic [CNT_W-1:0]  tally [C];
  logic [IDX_W-1:0]  idx;
  logic [SC_W-1:0]   sc;
  logic [CNT_W-1:0]  best_cnt;
  logic [LBL_W-1:0]  best_cls;
  logic              any_vote;   // at least one non-empty entry was seen
  logic              take;       // class sc beats the current best

`ifdef KNN_VOTE_TIEBRK_EN
  logic [DATA_W-1:0] snap_dist [K];
  logic [DATA_W-1:0] min_dist [C];
  logic [DATA_W-1:0] best_dist;
`else
  logic unused_dist;
  always_comb begin
    unused_dist = 1'b0;
    for (int i = 0; i < K; i++)
      unused_dist = unused_dist ^ (^nb[2*i*DATA_W +: DATA_W]);
  end
`endif

  always_comb begin
    take = tally[sc] > best_cnt;
`ifdef KNN_VOTE_TIEBRK_EN
    if (tally[sc] == best_cnt && min_dist[sc] < best_dist)
      take = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lbl_req     <= 1'b0;
      lbl_addr    <= '0;
      class_out   <= '0;
      class_valid <= 1'b0;
      busy        <= 1'b0;
      no_vote     <= 1'b0;
      lbl_err     <= 1'b0;
      idx         <= '0;
      sc          <= '0;
      best_cnt    <= '0;
      best_cls    <= '0;
      any_vote    <= 1'b0;
      for (int i = 0; i < K; i++) snap_idx[i] <= '0;
      for (int c = 0; c < C; c++) tally[c] <= '0;
`ifdef KNN_VOTE_TIEBRK_EN
      best_dist <= '1;
      for (int i = 0; i < K; i++) snap_dist[i] <= '0;
      for (int c = 0; c < C; c++) min_dist[c] <= '1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < K; i++) snap_idx[i] <= nb[(2*i+1)*DATA_W +: DATA_W];
            for (int c = 0; c < C; c++) tally[c] <= '0;
`ifdef KNN_VOTE_TIEBRK_EN
            for (int i = 0; i < K; i++) snap_dist[i] <= nb[2*i*DATA_W +: DATA_W];
            for (int c = 0; c < C; c++) min_dist[c] <= '1;
`endif
            // Present entry 0 straight from nb so it is on the bus in the
            // first FETCH cycle.
            lbl_req  <= nb[DATA_W +: DATA_W] != EMPTY;
            lbl_addr <= nb[DATA_W +: DATA_W];
            idx      <= '0;
            any_vote <= 1'b0;
            no_vote  <= 1'b0;
            lbl_err  <= 1'b0;
            busy     <= 1'b1;
            state    <= FETCH;
          end
        end

        FETCH: begin
          if (lbl_req) any_vote <= 1'b1;
          if (lbl_req && lbl_ack) begin
            if (int'(lbl_data) < C) begin
              for (int c = 0; c < C; c++) begin
                if (int'(lbl_data) == c) begin
                  tally[c] <= tally[c] + 1'b1;
`ifdef KNN_VOTE_TIEBRK_EN
                  if (snap_dist[idx] < min_dist[c]) min_dist[c] <= snap_dist[idx];
`endif
                end
              end
            end else begin
              lbl_err <= 1'b1;
            end
          end
          // lbl_req low means the current entry is empty: it takes one cycle.
          if (!lbl_req || lbl_ack) begin
            if (idx == IDX_W'(K-1)) begin
              lbl_req  <= 1'b0;
              sc       <= '0;
              best_cnt <= '0;
              best_cls <= '0;
`ifdef KNN_VOTE_TIEBRK_EN
              best_dist <= '1;
`endif
              state    <= SCAN;
            end else begin
              idx      <= idx + 1'b1;
              lbl_req  <= snap_idx[idx + 1'b1] != EMPTY;
              lbl_addr <= snap_idx[idx + 1'b1];
            end
          end
        end

        SCAN: begin
          if (take) begin
            best_cnt <= tally[sc];
            best_cls <= LBL_W'(sc);
`ifdef KNN_VOTE_TIEBRK_EN
            best_dist <= min_dist[sc];
`endif
          end
          if (sc == SC_W'(C-1)) begin
            class_out   <= !any_vote ? '0 : (take ? LBL_W'(sc) : best_cls);
            no_vote     <= !any_vote;
            class_valid <= 1'b1;
            state       <= DONE;
          end else begin
            sc <= sc + 1'b1;
          end
        end

        DONE: begin
          if (class_ready) begin
            class_valid <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_knn_vote.sv
// Directed bench for knn_vote (K=4, C=4, LBL_W=3 so out-of-range labels can be
// driven). A label responder answers lbl_req after ack_delay wait cycles,
// looking labels up in lbl_mem by the low address bits.
// Timing: start is sampled at edge t; a register updated at edge t+n is high in
// cycle t+n+1, so "class_valid at cycle t+9" means it is set by edge t+8.
module tb_knn_vote;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [255:0] nb;
  logic         lbl_req;
  logic [31:0]  lbl_addr;
  logic         lbl_ack = 1'b0;
  logic [2:0]   lbl_data = '0;
  logic [2:0]   class_out;
  logic         class_valid;
  logic         class_ready = 1'b1;
  logic         busy, no_vote, lbl_err;

  knn_vote #(.DATA_W(32), .K(4), .C(4), .LBL_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .nb(nb),
    .lbl_req(lbl_req), .lbl_addr(lbl_addr), .lbl_ack(lbl_ack), .lbl_data(lbl_data),
    .class_out(class_out), .class_valid(class_valid), .class_ready(class_ready),
    .busy(busy), .no_vote(no_vote), .lbl_err(lbl_err)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] nb_idx [4];
  logic [31:0] nb_dist [4];
  logic [2:0]  lbl_mem [16];

  always_comb begin
    nb = '0;
    for (int i = 0; i < 4; i++) begin
      nb[2*i*32 +: 32]     = nb_dist[i];
      nb[(2*i+1)*32 +: 32] = nb_idx[i];
    end
  end

  // Label responder.
  int          ack_delay = 0;
  int          wcnt = 0;
  int          stab_err = 0;
  bit          req_seen = 0;
  bit          prev_wait = 0;
  logic [31:0] prev_addr = '0;
  logic [31:0] order_q [$];

  always @(negedge clk) begin
    if (lbl_req && prev_wait && lbl_addr !== prev_addr) stab_err++;
    if (!lbl_req) begin
      lbl_ack = 1'b0;
      wcnt = 0;
    end else begin
      req_seen = 1;
      if (wcnt >= ack_delay) begin
        lbl_ack  = 1'b1;
        lbl_data = lbl_mem[lbl_addr[3:0]];
        order_q.push_back(lbl_addr);
        wcnt = 0;
      end else begin
        lbl_ack = 1'b0;
        wcnt++;
      end
    end
    prev_wait = lbl_req && !lbl_ack;
    prev_addr = lbl_addr;
  end

  // Neighbours at indices 4..7 with the given labels and distances.
  task automatic set_case(input logic [2:0] l0, l1, l2, l3,
                          input logic [31:0] d0, d1, d2, d3);
    nb_idx[0] = 32'd4; nb_idx[1] = 32'd5; nb_idx[2] = 32'd6; nb_idx[3] = 32'd7;
    nb_dist[0] = d0; nb_dist[1] = d1; nb_dist[2] = d2; nb_dist[3] = d3;
    lbl_mem[4] = l0; lbl_mem[5] = l1; lbl_mem[6] = l2; lbl_mem[7] = l3;
    order_q.delete();
    stab_err = 0;
    req_seen = 0;
  endtask

  // Pulse start (sampled at edge t) and return n where class_valid is first
  // set by edge t+n; -1 if it never rises within the budget.
  task automatic run_classify(output int n);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (class_valid) begin n = i; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({busy, lbl_req, class_valid, no_vote, lbl_err, class_out} !== 8'b0)
      $display("FAIL reset_outputs: got %b want 00000000",
               {busy, lbl_req, class_valid, no_vote, lbl_err, class_out});
    else pass_cnt++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic;
    int n;
    set_case(3'd2, 3'd2, 3'd1, 3'd3, 32'd10, 32'd20, 32'd30, 32'd40);
    ack_delay = 0;
    run_classify(n);
    total_cnt++;
    if (n !== 8) $display("FAIL basic_latency: edges %0d want 8 (cycle t+9)", n);
    else pass_cnt++;
    total_cnt++;
    if ({class_out, lbl_err, no_vote} !== {3'd2, 1'b0, 1'b0})
      $display("FAIL basic_result: class %0d err %0d nv %0d want 2 0 0", class_out, lbl_err, no_vote);
    else pass_cnt++;
    total_cnt++;
    if (order_q.size() != 4 || order_q[0] !== 32'd4 || order_q[3] !== 32'd7)
      $display("FAIL basic_order: %0d addresses acked, want 4..7", order_q.size());
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if ({class_valid, busy} !== 2'b00)
      $display("FAIL basic_release: valid %0d busy %0d want 0 0", class_valid, busy);
    else pass_cnt++;
  endtask

  task automatic test_ack_delay;
    int n;
    set_case(3'd2, 3'd2, 3'd1, 3'd3, 32'd10, 32'd20, 32'd30, 32'd40);
    ack_delay = 3;
    run_classify(n);
    ack_delay = 0;
    total_cnt++;
    if (n !== 20) $display("FAIL delay_latency: edges %0d want 20 (cycle t+21)", n);
    else pass_cnt++;
    total_cnt++;
    if (stab_err !== 0) $display("FAIL delay_stable: %0d addr changes while waiting, want 0", stab_err);
    else pass_cnt++;
    total_cnt++;
    if (order_q.size() != 4 || order_q[0] !== 32'd4 || order_q[1] !== 32'd5 ||
        order_q[2] !== 32'd6 || order_q[3] !== 32'd7)
      $display("FAIL delay_order: %0d addresses, want 4,5,6,7 in order", order_q.size());
    else pass_cnt++;
    total_cnt++;
    if (class_out !== 3'd2) $display("FAIL delay_class: got %0d want 2", class_out);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_empty;
    int n;
    set_case(3'd1, 3'd1, 3'd1, 3'd1, 32'd1, 32'd1, 32'd1, 32'd1);
    for (int i = 0; i < 4; i++) nb_idx[i] = 32'hFFFF_FFFF;
    run_classify(n);
    total_cnt++;
    if (n !== 8) $display("FAIL empty_latency: edges %0d want 8", n);
    else pass_cnt++;
    total_cnt++;
    if (req_seen !== 1'b0) $display("FAIL empty_noreq: lbl_req seen %0d want 0", req_seen);
    else pass_cnt++;
    total_cnt++;
    if ({no_vote, class_out} !== {1'b1, 3'd0})
      $display("FAIL empty_result: nv %0d class %0d want 1 0", no_vote, class_out);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_tiebreak;
    int n;
    logic [2:0] exp_cls;
`ifdef KNN_VOTE_TIEBRK_EN
    exp_cls = 3'd3;
`else
    exp_cls = 3'd1;
`endif
    set_case(3'd1, 3'd3, 3'd3, 3'd1, 32'd5, 32'd2, 32'd9, 32'd8);
    run_classify(n);
    total_cnt++;
    if (class_out !== exp_cls) $display("FAIL tiebreak_class: got %0d want %0d", class_out, exp_cls);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_lbl_err;
    int n;
    set_case(3'd7, 3'd0, 3'd0, 3'd1, 32'd1, 32'd2, 32'd3, 32'd4);
    run_classify(n);
    total_cnt++;
    if ({class_out, lbl_err, no_vote} !== {3'd0, 1'b1, 1'b0})
      $display("FAIL lblerr_result: class %0d err %0d nv %0d want 0 1 0", class_out, lbl_err, no_vote);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (lbl_err !== 1'b1) $display("FAIL lblerr_sticky: got %0d want 1", lbl_err);
    else pass_cnt++;
    set_case(3'd2, 3'd2, 3'd1, 3'd3, 32'd1, 32'd2, 32'd3, 32'd4);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    total_cnt++;
    if (lbl_err !== 1'b0) $display("FAIL lblerr_clear: got %0d want 0", lbl_err);
    else pass_cnt++;
    for (int i = 0; i < 200 && !class_valid; i++) begin @(posedge clk); #1; end
    total_cnt++;
    if ({class_valid, class_out} !== {1'b1, 3'd2})
      $display("FAIL lblerr_rerun: valid %0d class %0d want 1 2", class_valid, class_out);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_rst_abort;
    int n;
    set_case(3'd2, 3'd2, 3'd1, 3'd3, 32'd1, 32'd2, 32'd3, 32'd4);
    ack_delay = 100;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (lbl_req !== 1'b1) $display("FAIL abort_req_wait: lbl_req %0d want 1", lbl_req);
    else pass_cnt++;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    total_cnt++;
    if ({busy, lbl_req, class_valid} !== 3'b000)
      $display("FAIL abort_state: busy %0d req %0d valid %0d want 0 0 0", busy, lbl_req, class_valid);
    else pass_cnt++;
    ack_delay = 0;
    set_case(3'd1, 3'd0, 3'd1, 3'd2, 32'd1, 32'd2, 32'd3, 32'd4);
    run_classify(n);
    total_cnt++;
    if (n !== 8 || class_out !== 3'd1)
      $display("FAIL abort_rerun: edges %0d class %0d want 8 1", n, class_out);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_done_hold;
    int n;
    logic [2:0] held;
    set_case(3'd3, 3'd0, 3'd3, 3'd2, 32'd1, 32'd2, 32'd3, 32'd4);
    class_ready = 1'b0;
    run_classify(n);
    held = class_out;
    total_cnt++;
    if (held !== 3'd3) $display("FAIL hold_class: got %0d want 3", held);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); start = (i % 2 == 0);
      @(posedge clk); #1;
      total_cnt++;
      if ({class_valid, busy, class_out} !== {1'b1, 1'b1, 3'd3})
        $display("FAIL hold_cycle%0d: valid %0d busy %0d class %0d want 1 1 3",
                 i, class_valid, busy, class_out);
      else pass_cnt++;
    end
    @(negedge clk); class_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    total_cnt++;
    if ({class_valid, busy} !== 2'b00)
      $display("FAIL hold_release: valid %0d busy %0d want 0 0", class_valid, busy);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if ({busy, lbl_req} !== 2'b00)
      $display("FAIL hold_start_ignored: busy %0d req %0d want 0 0", busy, lbl_req);
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) lbl_mem[i] = '0;
    for (int i = 0; i < 4; i++) begin nb_idx[i] = '0; nb_dist[i] = '0; end
    test_reset();
    test_basic();
    test_ack_delay();
    test_empty();
    test_tiebreak();
    test_lbl_err();
    test_rst_abort();
    test_done_hold();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
